// File: rtl/shift_issue_queue_if.sv
// Operand-in and result-out valid/ready streams of the shift issue queue.
interface shift_issue_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  // Master drives operands and consumes results; slave is the queue itself.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/shift_issue_queue.sv
// FIFO of operand pairs feeding an external 16-bit right shifter, with a
// registered, back-pressurable result stage and a wrapping hand-off counter.
module shift_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  shift_issue_queue_if.slave  bus,
  output logic [15:0]         sh_a,
  output logic [15:0]         sh_b,
  input  logic [15:0]         sh_out,
  output logic [CNT_W-1:0]    op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [15:0]      mem_a [DEPTH];
  logic [15:0]      mem_b [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             out_valid_q;
  logic [15:0]      out_data_q;
  logic             out_ovf_q;

  logic not_empty;
  logic push;
  logic load;
  logic hand_off;
  logic head_ovf;

  assign not_empty = (count != '0);
  assign bus.in_ready = (count != FULL);
  assign push     = bus.in_valid && bus.in_ready;
  assign load     = not_empty && (!out_valid_q || bus.out_ready);
  assign hand_off = out_valid_q && bus.out_ready;

  assign sh_a = not_empty ? mem_a[rptr] : 16'h0000;
  assign sh_b = not_empty ? mem_b[rptr] : 16'h0000;
  assign head_ovf = |sh_b[15:4];

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= bus.in_a;
      mem_b[wptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Amounts of 16 or more shift everything out, whatever the shifter returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_ovf_q   <= 1'b0;
      op_count    <= '0;
    end else begin
      if (load) begin
        out_data_q  <= head_ovf ? 16'h0000 : sh_out;
        out_ovf_q   <= head_ovf;
        out_valid_q <= 1'b1;
      end else if (hand_off) begin
        out_valid_q <= 1'b0;
      end
      if (hand_off) op_count <= op_count + 1'b1;
    end
  end

endmodule
